// File: rtl/programm_lader_pkg.sv
// programm_lader shared definitions
// state encoding, word geometry, address width helper
package programm_lader_pkg;

  localparam int WORDSIZE_STD   = 32;
  localparam int WORDS_STD      = 256;
  localparam int BYTES_PRO_WORT = WORDSIZE_STD / 8;

  typedef enum logic [2:0] {
    LEERLAUF,
    EMPFANGEN,
    SCHREIBEN,
    QUITTIEREN,
    FERTIG,
    FEHLER
  } zustand_t;

  function automatic int adr_breite(input int worte);
    return (worte > 1) ? $clog2(worte) : 1;
  endfunction

endpackage

// File: rtl/programm_lader_if.sv
// programm_lader host byte stream and instruction-RAM write bus
// master = loader side, slave = host/RAM side
interface programm_lader_if
  import programm_lader_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_STD
);

  logic [7:0]          ByteRein;
  logic                ByteGueltig;
  logic                ByteBereit;
  logic [31:0]         Adresse;
  logic [WORDSIZE-1:0] DatenRaus;
  logic                SchreibenAn;
  logic                DatenGeschrieben;

  modport master (
    input  ByteRein, ByteGueltig, DatenGeschrieben,
    output ByteBereit, Adresse, DatenRaus, SchreibenAn
  );

  modport slave (
    output ByteRein, ByteGueltig, DatenGeschrieben,
    input  ByteBereit, Adresse, DatenRaus, SchreibenAn
  );

endinterface

// File: rtl/programm_lader_wort_sammler.sv
// wort_sammler: big-endian byte packer
// wort is the word including the byte strobed this cycle
module wort_sammler
  import programm_lader_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_STD
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                strobe,
  input  logic                clear,
  input  logic [7:0]          byte_in,
  output logic [WORDSIZE-1:0] wort,
  output logic                voll
);

  localparam int BPW = WORDSIZE / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORDSIZE-1:0] schieb_q, schieb_d;
  logic [CW-1:0]       zahl_q, zahl_d;

  assign wort = (schieb_q << 8) | WORDSIZE'(byte_in);
  assign voll = strobe && (zahl_q == CW'(BPW - 1));

  // shift in bytes; restart after a full word or on clear
  always_comb begin
    schieb_d = schieb_q;
    zahl_d   = zahl_q;
    if (clear || voll) begin
      schieb_d = '0;
      zahl_d   = '0;
    end else if (strobe) begin
      schieb_d = wort;
      zahl_d   = zahl_q + CW'(1);
    end
  end

  // shift register and byte counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      schieb_q <= '0;
      zahl_q   <= '0;
    end else begin
      schieb_q <= schieb_d;
      zahl_q   <= zahl_d;
    end
  end

endmodule

// File: rtl/programm_lader.sv
// programm_lader: streams bytes into instruction RAM
// holds the CPU in reset until the last word is acknowledged
module programm_lader
  import programm_lader_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_STD,
  parameter int WORDS    = WORDS_STD
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [31:0]  AnzahlWorte,
  programm_lader_if.master bus,
  output logic         CPUReset,
  output logic         Fertig,
  output logic         Fehler
);

  localparam int AW = adr_breite(WORDS);

  zustand_t            state_q, state_d;
  logic [AW-1:0]       adr_q, adr_d;
  logic [31:0]         anz_q, anz_d;
  logic [WORDSIZE-1:0] daten_q, daten_d;
  logic                bb_q, bb_d;
  logic                wr_q, wr_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                fertig_q, fertig_d;
  logic                fehler_q, fehler_d;

  logic                strobe;
  logic                clear;
  logic                voll;
  logic [WORDSIZE-1:0] wort;
  logic                ungueltig;
  logic                letztes;

  assign strobe    = bb_q && bus.ByteGueltig;
  assign ungueltig = (AnzahlWorte == 32'd0) ||
                     (AnzahlWorte > 32'(WORDS));
  assign letztes   = (32'(adr_q) == anz_q - 32'd1);

  wort_sammler #(
    .WORDSIZE(WORDSIZE)
  ) u_sammler (
    .Clock  (Clock),
    .Reset  (Reset),
    .strobe (strobe),
    .clear  (clear),
    .byte_in(bus.ByteRein),
    .wort   (wort),
    .voll   (voll)
  );

  // next state; outputs registered from the next state
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    anz_d   = anz_q;
    daten_d = daten_q;
    clear   = 1'b0;
    unique case (state_q)
      LEERLAUF, FERTIG, FEHLER: begin
        if (Start) begin
          anz_d   = AnzahlWorte;
          adr_d   = '0;
          clear   = 1'b1;
          state_d = ungueltig ? FEHLER : EMPFANGEN;
        end
      end
      EMPFANGEN: begin
        if (voll) begin
          daten_d = wort;
          state_d = SCHREIBEN;
        end
      end
      SCHREIBEN: begin
        if (bus.DatenGeschrieben) state_d = QUITTIEREN;
      end
      QUITTIEREN: begin
        if (!bus.DatenGeschrieben) begin
          if (letztes) begin
            state_d = FERTIG;
          end else begin
            adr_d   = adr_q + AW'(1);
            state_d = EMPFANGEN;
          end
        end
      end
      default: state_d = LEERLAUF;
    endcase
    bb_d      = (state_d == EMPFANGEN);
    wr_d      = (state_d == SCHREIBEN);
    fertig_d  = (state_d == FERTIG);
    fehler_d  = (state_d == FEHLER);
    cpu_rst_d = (state_d != FERTIG);
  end

  // state, address, data and output flops
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= LEERLAUF;
      adr_q     <= '0;
      anz_q     <= '0;
      daten_q   <= '0;
      bb_q      <= 1'b0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      fertig_q  <= 1'b0;
      fehler_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      anz_q     <= anz_d;
      daten_q   <= daten_d;
      bb_q      <= bb_d;
      wr_q      <= wr_d;
      cpu_rst_q <= cpu_rst_d;
      fertig_q  <= fertig_d;
      fehler_q  <= fehler_d;
    end
  end

  assign bus.ByteBereit  = bb_q;
  assign bus.SchreibenAn = wr_q;
  assign bus.Adresse     = 32'(adr_q);
  assign bus.DatenRaus   = daten_q;
  assign CPUReset        = cpu_rst_q;
  assign Fertig          = fertig_q;
  assign Fehler          = fehler_q;

endmodule
